// File: rtl/vga_pkg.sv
// Shared VGA-side constants, blitter state encoding and a counter-width helper.
package vga_pkg;

   localparam int unsigned VGA_X_W  = 8;
   localparam int unsigned VGA_Y_W  = 7;
   localparam int unsigned COLOUR_W = 3;

   localparam logic [2:0] COL_BLACK  = 3'b000;
   localparam logic [2:0] COL_YELLOW = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_DRAW  = 3'd3,
      ST_DONE  = 3'd4
   } blit_state_t;

   // Counter width that stays at least one bit for single-entry ranges.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/blit_cell_counter.sv
// Nested px (fastest) / py / col counter; every field wraps to 0 at its terminal value.
module blit_cell_counter #(
   parameter int unsigned COLS   = 16,
   parameter int unsigned CELL_W = 2,
   parameter int unsigned CELL_H = 2,
   localparam int unsigned PX_W  = vga_pkg::cnt_w(CELL_W),
   localparam int unsigned PY_W  = vga_pkg::cnt_w(CELL_H),
   localparam int unsigned COL_W = vga_pkg::cnt_w(COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   output logic [PX_W-1:0]  px,
   output logic [PY_W-1:0]  py,
   output logic [COL_W-1:0] col,
   output logic             cell_end_c,
   output logic             term_c
);

   logic px_last_c;
   logic py_last_c;
   logic col_last_c;

   always_comb begin
      px_last_c  = (px == PX_W'(CELL_W - 1));
      py_last_c  = (py == PY_W'(CELL_H - 1));
      col_last_c = (col == COL_W'(COLS - 1));
      cell_end_c = px_last_c && py_last_c;
      term_c     = cell_end_c && col_last_c;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         px  <= '0;
         py  <= '0;
         col <= '0;
      end else if (en) begin
         if (!px_last_c) begin
            px <= px + PX_W'(1);
         end else begin
            px <= '0;
            if (!py_last_c) begin
               py <= py + PY_W'(1);
            end else begin
               py  <= '0;
               col <= col_last_c ? '0 : col + COL_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/bitmap_blitter.sv
// Draws a ROWS x COLS one-bit glyph as CELL_W x CELL_H pixel blocks into the VGA adapter.
module bitmap_blitter #(
   parameter int unsigned COLS     = 16,
   parameter int unsigned ROWS     = 16,
   parameter int unsigned CELL_W   = 2,
   parameter int unsigned CELL_H   = 2,
   parameter int unsigned PITCH_X  = 10,
   parameter int unsigned PITCH_Y  = 7,
   parameter int unsigned X_W      = vga_pkg::VGA_X_W,
   parameter int unsigned Y_W      = vga_pkg::VGA_Y_W,
   parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W,
   localparam int unsigned ROW_W   = vga_pkg::cnt_w(ROWS)
) (
   input  logic                fastclock,
   input  logic                reset,
   input  logic                start,
   input  logic [X_W-1:0]      origin_x,
   input  logic [Y_W-1:0]      origin_y,
   input  logic [COLOUR_W-1:0] fg_colour,
   input  logic [COLOUR_W-1:0] bg_colour,
   input  logic                transparent,
   output logic [ROW_W-1:0]    row_addr,
   input  logic [COLS-1:0]     row_data,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   import vga_pkg::*;

   localparam int unsigned PX_W  = cnt_w(CELL_W);
   localparam int unsigned PY_W  = cnt_w(CELL_H);
   localparam int unsigned COL_W = cnt_w(COLS);
   localparam int unsigned XF_W  = X_W + 6;
   localparam int unsigned YF_W  = Y_W + 6;

   blit_state_t         state;
   logic [X_W-1:0]      org_x;
   logic [Y_W-1:0]      org_y;
   logic [COLOUR_W-1:0] fg;
   logic [COLOUR_W-1:0] bg;
   logic                trans;
   logic [COLS-1:0]     shreg;

   logic [PX_W-1:0]  px;
   logic [PY_W-1:0]  py;
   logic [COL_W-1:0] col;
   logic             cell_end_c;
   logic             term_c;
   logic             cnt_clear_c;
   logic             cnt_en_c;
   logic             bit_c;
   logic [XF_W-1:0]  x_full_c;
   logic [YF_W-1:0]  y_full_c;

   // row_addr doubles as the row counter, so it is stable throughout FETCH.
   always_comb begin
      cnt_clear_c = (state == ST_IDLE) && start;
      cnt_en_c    = (state == ST_DRAW);
      bit_c       = shreg[COLS-1];
      x_full_c    = XF_W'(org_x) + XF_W'(col) * XF_W'(PITCH_X) + XF_W'(px);
      y_full_c    = YF_W'(org_y) + YF_W'(row_addr) * YF_W'(PITCH_Y) + YF_W'(py);
   end

   blit_cell_counter #(
      .COLS   (COLS),
      .CELL_W (CELL_W),
      .CELL_H (CELL_H)
   ) u_cnt (
      .clk        (fastclock),
      .rst        (reset),
      .clear      (cnt_clear_c),
      .en         (cnt_en_c),
      .px         (px),
      .py         (py),
      .col        (col),
      .cell_end_c (cell_end_c),
      .term_c     (term_c)
   );

   always_ff @(posedge fastclock) begin
      if (reset) begin
         state    <= ST_IDLE;
         org_x    <= '0;
         org_y    <= '0;
         fg       <= '0;
         bg       <= '0;
         trans    <= 1'b0;
         shreg    <= '0;
         row_addr <= '0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         plot     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  org_x    <= origin_x;
                  org_y    <= origin_y;
                  fg       <= fg_colour;
                  bg       <= bg_colour;
                  trans    <= transparent;
                  row_addr <= '0;
                  busy     <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_LATCH;
            ST_LATCH: begin
               shreg <= row_data;
               state <= ST_DRAW;
            end
            ST_DRAW: begin
               x <= X_W'(x_full_c);
               y <= Y_W'(y_full_c);
               // Transparent clear bits still burn their cycle to keep timing fixed.
               if (trans && !bit_c) begin
                  colour <= '0;
               end else begin
                  colour <= bit_c ? fg : bg;
                  plot   <= 1'b1;
               end
               if (cell_end_c) shreg <= shreg << 1;
               if (term_c) begin
                  if (row_addr == ROW_W'(ROWS - 1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     row_addr <= row_addr + ROW_W'(1);
                     state    <= ST_FETCH;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitmap_blitter.sv
// Directed bench for bitmap_blitter: default 16x16 instance plus an 8x4 1x1-cell variant.
module tb_bitmap_blitter;

   typedef struct {
      logic [7:0]  ox;
      logic [6:0]  oy;
      logic [2:0]  fg;
      logic [2:0]  bg;
      logic        tr;
      logic [15:0] row0;
      int          n_plots;
      int          first_k;
      logic [7:0]  x0;
      logic [6:0]  y0;
      logic [2:0]  c0;
      int          i1;
      logic [7:0]  x1;
      logic [6:0]  y1;
      logic [2:0]  c1;
   } vec_t;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic        fastclock;
   logic        reset;
   logic        start;
   logic [7:0]  origin_x;
   logic [6:0]  origin_y;
   logic [2:0]  fg_colour;
   logic [2:0]  bg_colour;
   logic        transparent;
   logic [3:0]  row_addr;
   logic [15:0] row_data;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        done;

   logic        start2;
   logic [1:0]  row_addr2;
   logic [7:0]  row_data2;
   logic [7:0]  x2;
   logic [6:0]  y2;
   logic [2:0]  colour2;
   logic        plot2;
   logic        busy2;
   logic        done2;

   logic [15:0] rom [16];
   logic [7:0]  rom2 [4];

   int   n_vec = 0;
   int   n_bad = 0;
   logic mon_en = 1'b0;
   int   busy_cnt, done_cnt;
   pix_t plots[$];
   int   busy2_cnt, done2_cnt, plot2_cnt, oor2_cnt;
   logic seen2 [8][4];
   int   first_k;

   bitmap_blitter dut (
      .fastclock   (fastclock),
      .reset       (reset),
      .start       (start),
      .origin_x    (origin_x),
      .origin_y    (origin_y),
      .fg_colour   (fg_colour),
      .bg_colour   (bg_colour),
      .transparent (transparent),
      .row_addr    (row_addr),
      .row_data    (row_data),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot),
      .busy        (busy),
      .done        (done)
   );

   bitmap_blitter #(
      .COLS(8), .ROWS(4), .CELL_W(1), .CELL_H(1), .PITCH_X(1), .PITCH_Y(1)
   ) dut2 (
      .fastclock   (fastclock),
      .reset       (reset),
      .start       (start2),
      .origin_x    (8'd20),
      .origin_y    (7'd30),
      .fg_colour   (3'b110),
      .bg_colour   (3'b001),
      .transparent (1'b0),
      .row_addr    (row_addr2),
      .row_data    (row_data2),
      .x           (x2),
      .y           (y2),
      .colour      (colour2),
      .plot        (plot2),
      .busy        (busy2),
      .done        (done2)
   );

   initial fastclock = 1'b0;
   always #5 fastclock = ~fastclock;

   // Synchronous glyph ROMs: data appears one cycle after the address.
   always @(posedge fastclock) begin
      row_data  <= rom[row_addr];
      row_data2 <= rom2[row_addr2];
   end

   always @(negedge fastclock) begin
      if (mon_en) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (plot) plots.push_back('{x: x, y: y, c: colour});
         if (busy2) busy2_cnt++;
         if (done2) done2_cnt++;
         if (plot2) begin
            plot2_cnt++;
            if (x2 >= 8'd20 && x2 <= 8'd27 && y2 >= 7'd30 && y2 <= 7'd33)
               seen2[int'(x2) - 20][int'(y2) - 30] = 1'b1;
            else
               oor2_cnt++;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_pix(input string name, input int idx, input logic [7:0] ex,
                          input logic [6:0] ey, input logic [2:0] ec);
      if (plots.size() > idx) begin
         chk({name, ".x"}, 64'(plots[idx].x), 64'(ex));
         chk({name, ".y"}, 64'(plots[idx].y), 64'(ey));
         chk({name, ".c"}, 64'(plots[idx].c), 64'(ec));
      end else begin
         chk({name, ".present"}, 64'(plots.size()), 64'(idx + 1));
      end
   endtask

   // One full draw; optionally re-pulses start with a different origin mid-draw.
   task automatic run_draw(input vec_t v, input int restart_at);
      int k;
      for (int r = 0; r < 16; r++) rom[r] = 16'h0000;
      rom[0] = v.row0;
      plots.delete();
      busy_cnt = 0;
      done_cnt = 0;
      first_k  = -1;
      mon_en   = 1'b1;
      origin_x = v.ox; origin_y = v.oy; fg_colour = v.fg; bg_colour = v.bg;
      transparent = v.tr;
      start = 1'b1;
      @(posedge fastclock); #1;
      start = 1'b0;
      k = 0;
      while (k < 3000) begin
         @(posedge fastclock); #1;
         k++;
         if (k == restart_at) begin
            origin_x = 8'd99;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (plot && first_k < 0) first_k = k;
         if (done) break;
      end
      if (!done) chk("draw_timeout", 64'(k), 64'(0));
      @(negedge fastclock);
      @(posedge fastclock); #1;
      mon_en = 1'b0;
   endtask

   vec_t tbl [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'd0,   7'd0,   3'd6, 3'd0, 1'b0, 16'h8000, 1024, 3,
                 8'd0, 7'd0,  3'd6, 4,   8'd10,  7'd0,  3'd0};
      tbl[1] = '{8'd0,   7'd0,   3'd6, 3'd0, 1'b1, 16'h8000, 4,    3,
                 8'd0, 7'd0,  3'd6, 3,   8'd1,   7'd1,  3'd6};
      tbl[2] = '{8'd250, 7'd0,   3'd6, 3'd0, 1'b1, 16'h4000, 4,    7,
                 8'd4, 7'd0,  3'd6, 3,   8'd5,   7'd1,  3'd6};
      tbl[3] = '{8'd5,   7'd3,   3'd3, 3'd5, 1'b0, 16'h0001, 1024, 3,
                 8'd5, 7'd3,  3'd5, 60,  8'd155, 7'd3,  3'd3};
      tbl[4] = '{8'd0,   7'd100, 3'd7, 3'd2, 1'b0, 16'h0000, 1024, 3,
                 8'd0, 7'd100, 3'd2, 960, 8'd0,  7'd77, 3'd2};

      for (int r = 0; r < 16; r++) rom[r] = 16'h0000;
      for (int r = 0; r < 4; r++) rom2[r] = 8'hFF;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++) seen2[i][j] = 1'b0;
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      origin_x = '0; origin_y = '0; fg_colour = '0; bg_colour = '0; transparent = 1'b0;
      repeat (3) @(posedge fastclock);
      #1;
      chk("rst.plot",     64'(plot),     64'(0));
      chk("rst.busy",     64'(busy),     64'(0));
      chk("rst.done",     64'(done),     64'(0));
      chk("rst.x",        64'(x),        64'(0));
      chk("rst.y",        64'(y),        64'(0));
      chk("rst.colour",   64'(colour),   64'(0));
      chk("rst.row_addr", 64'(row_addr), 64'(0));
      reset = 1'b0;
      @(posedge fastclock); #1;

      for (int i = 0; i < 5; i++) begin
         run_draw(tbl[i], 0);
         chk($sformatf("v%0d.plots", i),   64'(plots.size()), 64'(tbl[i].n_plots));
         chk($sformatf("v%0d.busy", i),    64'(busy_cnt),     64'(1056));
         chk($sformatf("v%0d.done", i),    64'(done_cnt),     64'(1));
         chk($sformatf("v%0d.first_k", i), 64'(first_k),      64'(tbl[i].first_k));
         chk_pix($sformatf("v%0d.p0", i), 0, tbl[i].x0, tbl[i].y0, tbl[i].c0);
         chk_pix($sformatf("v%0d.p%0d", i, tbl[i].i1), tbl[i].i1, tbl[i].x1, tbl[i].y1, tbl[i].c1);
         if (i == 0) begin
            chk_pix("v0.p1", 1, 8'd1, 7'd0, 3'd6);
            chk_pix("v0.p2", 2, 8'd0, 7'd1, 3'd6);
            chk_pix("v0.p3", 3, 8'd1, 7'd1, 3'd6);
         end
      end

      // Second start at cycle 50 must be ignored.
      run_draw(tbl[0], 50);
      chk("restart.busy",  64'(busy_cnt),     64'(1056));
      chk("restart.done",  64'(done_cnt),     64'(1));
      chk("restart.plots", 64'(plots.size()), 64'(1024));
      chk_pix("restart.p4", 4, 8'd10, 7'd0, 3'd0);
      chk_pix("restart.p1023", 1023, 8'd151, 7'd106, 3'd0);
      @(posedge fastclock); #1;
      chk("restart.idle", 64'(busy), 64'(0));

      // Synchronous reset in the middle of a draw.
      origin_x = 8'd40; origin_y = 7'd20; fg_colour = 3'd6; bg_colour = 3'd1; transparent = 1'b0;
      start = 1'b1;
      @(posedge fastclock); #1;
      start = 1'b0;
      repeat (99) @(posedge fastclock);
      #1;
      chk("midrst.pre_busy", 64'(busy), 64'(1));
      reset = 1'b1;
      @(posedge fastclock); #1;
      chk("midrst.plot",     64'(plot),     64'(0));
      chk("midrst.busy",     64'(busy),     64'(0));
      chk("midrst.done",     64'(done),     64'(0));
      chk("midrst.x",        64'(x),        64'(0));
      chk("midrst.y",        64'(y),        64'(0));
      chk("midrst.row_addr", 64'(row_addr), 64'(0));
      reset = 1'b0;
      @(posedge fastclock); #1;
      run_draw(tbl[0], 0);
      chk("postrst.busy",  64'(busy_cnt),     64'(1056));
      chk("postrst.plots", 64'(plots.size()), 64'(1024));
      chk_pix("postrst.p0", 0, 8'd0, 7'd0, 3'd6);
      chk_pix("postrst.p4", 4, 8'd10, 7'd0, 3'd0);

      // 8x4 variant, 1x1 cells on a 1x1 pitch, all bits set.
      busy2_cnt = 0; done2_cnt = 0; plot2_cnt = 0; oor2_cnt = 0;
      mon_en = 1'b1;
      start2 = 1'b1;
      @(posedge fastclock); #1;
      start2 = 1'b0;
      begin
         int k;
         k = 0;
         while (k < 500 && !done2) begin
            @(posedge fastclock); #1;
            k++;
         end
         if (!done2) chk("var.timeout", 64'(k), 64'(0));
      end
      @(negedge fastclock);
      @(posedge fastclock); #1;
      mon_en = 1'b0;
      begin
         int cov;
         cov = 0;
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) if (seen2[i][j]) cov++;
         chk("var.plots",    64'(plot2_cnt), 64'(32));
         chk("var.coverage", 64'(cov),       64'(32));
         chk("var.oor",      64'(oor2_cnt),  64'(0));
         chk("var.busy",     64'(busy2_cnt), 64'(40));
         chk("var.done",     64'(done2_cnt), 64'(1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
